lut_sweep_checker: RTL and testbench
====================================

Name: lut_sweep_checker

Overview:
- Sequential self-check stage that drives the combinational quadratic LUT block: sweeps every xq code, compares LUT output against direct-function output, feeds the result back through the inverse-quadratic LUT, and counts round-trip matches.
- Sits directly upstream of the function LUT (owns its xq/yiq inputs, consumes yq_lut/yq_fun/xiq).
- Used as a built-in self-test after reset, or on demand under firmware control.

Parameters:
- W_X, 4: x code width; sweep covers N = 2**W_X points.
- W_Y, 8: y code width.
- LAT, 0: settle cycles allowed between driving the LUT and sampling it (0 = combinational LUT; >0 for a registered LUT).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep; ignored unless IDLE.
- abort  in  1  synchronous; returns to IDLE with no done pulse; counters hold their values.
- xq  out  W_X signed  drive to LUT quadratic input.
- yq_lut  in  W_Y signed  LUT quadratic result.
- yq_fun  in  W_Y signed  direct-function quadratic result.
- yiq  out  W_Y signed  drive to LUT inverse input.
- xiq  in  W_X signed  LUT inverse result.
- busy  out  1  high in FWD and INV.
- done  out  1  one-cycle pulse when a sweep completes.
- err_count  out  W_X+1  number of points with yq_lut != yq_fun.
- err_seen  out  1  sticky; set on the first mismatch of a sweep.
- first_err_x  out  W_X signed  xq value of the first mismatch.
- rt_match_count  out  W_X+1  number of points with xiq == x.

Behaviour:
- Reset: all outputs 0; state IDLE; x index 0; wait counter 0.
- States:
  - IDLE: start=1 clears the counters, err_seen, first_err_x and the index; drives xq <= 0; next state FWD.
  - FWD: wait counter counts 0..LAT. When it equals LAT:
    - sample yq_lut/yq_fun;
    - if they differ, increment err_count; if err_seen=0, also capture first_err_x <= xq and set err_seen;
    - yiq <= yq_lut; clear wait counter; next state INV.
  - INV: wait counter counts 0..LAT. When it equals LAT:
    - if xiq == xq, increment rt_match_count;
    - if index == N-1, next state DONE; otherwise increment index, xq <= index+1, next state FWD.
  - DONE: done=1 for one cycle; next state IDLE.
- Timing: 2*(LAT+1) cycles per point. With LAT=0 and start sampled at edge k, done is high in cycle k+2N+1.
- Sweep order: unsigned index 0..N-1, driven onto xq as a signed value (0..7, then -8..-1 for W_X=4).
- abort has priority over all transitions in FWD/INV/DONE. In DONE, abort suppresses the done pulse. xq/yiq hold their values.
- start while busy or in DONE: ignored, no effect.
- Simultaneous start and abort in IDLE: abort wins, no sweep.
- Counters are W_X+1 bits and cannot overflow (maximum value is N).
- rstn low mid-sweep: immediate return to reset values; no done.
- All comparisons are full-width signed equality; no arithmetic on LUT data.

Decomposition:
- Package lut_chk_pkg holds:
  - the state enum {IDLE, FWD, INV, DONE};
  - localparam function n_points(W_X) = 2**W_X;
  - count width W_X+1.
- One natural sub-module, lut_settle_timer: a LAT-cycle counter with clear and a reached output, reused by FWD and INV.

Test Plan:
- Pass sweep: W_X=4, W_Y=8, LAT=0, connected to the real function LUT (A=1, B=10, C=-10). Pulse start → busy for 32 cycles, done at start+33, err_count=0, err_seen=0. Check xq=0 → yiq=-10 and xiq=0 (counted as a match); rt_match_count equals the bench reference model.
- Fault injection: bench forces yq_lut = yq_fun+1 only when xq=3 → err_count=1, err_seen=1, first_err_x=3. Forcing at xq=3 and xq=-2 → err_count=2, first_err_x still 3.
- Latency: LAT=2 → xq changes every 6 cycles; done at start+97. With the LUT outputs registered twice, err_count=0.
- Abort: abort asserted in cycle 10 of a sweep → next cycle IDLE, busy=0, no done pulse, counters hold. A new start then clears the counters and the full sweep completes.
- start ignored: start pulses at cycles 5 and 20 of an active sweep → single done, counts unchanged versus a clean run.
- Reset mid-sweep: rstn low at cycle 15 → all outputs 0 asynchronously. After release and start, the full sweep reproduces the pass results.

Source files
------------

// File: rtl/lut_chk_pkg.sv
// Shared types and sizing helpers for the LUT sweep self-check stage.
// Counters hold 0..N, so they need one bit more than the x code.
package lut_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    INV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int n_points(input int w_x);
    return 2 ** w_x;
  endfunction

  function automatic int count_width(input int w_x);
    return w_x + 1;
  endfunction

endpackage

// File: rtl/lut_settle_timer.sv
// Counts 0..LAT settle cycles; reached stays high at LAT until cleared.
module lut_settle_timer #(
  parameter int LAT = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic reached
);

  localparam int TW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  assign reached = (cnt_q == TW'(LAT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !reached) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lut_sweep_checker.sv
// Sweeps every x code through the quadratic LUT, counts mismatches against the
// direct function, and counts inverse-LUT round trips that return the same x.
module lut_sweep_checker
  import lut_chk_pkg::*;
#(
  parameter int W_X = 4,
  parameter int W_Y = 8,
  parameter int LAT = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  output logic signed [W_X-1:0] xq,
  input  logic signed [W_Y-1:0] yq_lut,
  input  logic signed [W_Y-1:0] yq_fun,
  output logic signed [W_Y-1:0] yiq,
  input  logic signed [W_X-1:0] xiq,
  output logic                  busy,
  output logic                  done,
  output logic [W_X:0]          err_count,
  output logic                  err_seen,
  output logic signed [W_X-1:0] first_err_x,
  output logic [W_X:0]          rt_match_count
);

  localparam int CW = count_width(W_X);
  localparam logic [W_X-1:0] LAST_IDX = W_X'(n_points(W_X) - 1);

  state_e                state_q, state_d;
  logic [W_X-1:0]        idx_q, idx_d;
  logic signed [W_Y-1:0] yiq_q, yiq_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         err_cnt_q, err_cnt_d;
  logic                  err_seen_q, err_seen_d;
  logic signed [W_X-1:0] first_err_q, first_err_d;
  logic [CW-1:0]         rt_cnt_q, rt_cnt_d;
  logic                  timer_clr;
  logic                  reached;

  lut_settle_timer #(.LAT(LAT)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (timer_clr),
    .en      (busy_q),
    .reached (reached)
  );

  // The sweep index is unsigned; xq simply reinterprets it as a signed code.
  assign xq             = idx_q;
  assign yiq            = yiq_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_cnt_q;
  assign err_seen       = err_seen_q;
  assign first_err_x    = first_err_q;
  assign rt_match_count = rt_cnt_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    yiq_d       = yiq_q;
    done_d      = 1'b0;
    err_cnt_d   = err_cnt_q;
    err_seen_d  = err_seen_q;
    first_err_d = first_err_q;
    rt_cnt_d    = rt_cnt_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = FWD;
          idx_d       = '0;
          err_cnt_d   = '0;
          err_seen_d  = 1'b0;
          first_err_d = '0;
          rt_cnt_d    = '0;
        end
      end
      FWD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (reached) begin
          if (yq_lut != yq_fun) begin
            err_cnt_d = err_cnt_q + CW'(1);
            if (!err_seen_q) begin
              err_seen_d  = 1'b1;
              first_err_d = xq;
            end
          end
          yiq_d   = yq_lut;
          state_d = INV;
        end
      end
      INV: begin
        if (abort) begin
          state_d = IDLE;
        end else if (reached) begin
          if (xiq == xq) begin
            rt_cnt_d = rt_cnt_q + CW'(1);
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + W_X'(1);
            state_d = FWD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = !abort;
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d == FWD) || (state_d == INV);
    // Every state change restarts the settle count for the next phase.
    timer_clr = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      yiq_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      err_seen_q  <= 1'b0;
      first_err_q <= '0;
      rt_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      yiq_q       <= yiq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
      err_seen_q  <= err_seen_d;
      first_err_q <= first_err_d;
      rt_cnt_q    <= rt_cnt_d;
    end
  end

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Directed bench: a combinational LUT model (y = x^2 + 10x - 10) for LAT=0 and a
// twice-registered copy for LAT=2, with optional fault injection on yq_lut.
module tb_lut_sweep_checker;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
  logic fault_p3 = 1'b0, fault_m2 = 1'b0;

  logic signed [3:0] xq0, xiq0, first0, xq2, xiq2, first2;
  logic signed [7:0] yiq0, yq_lut0, yq_fun0, yiq2, yq_lut2, yq_fun2;
  logic signed [7:0] lut2_s1, lut2_s2, fun2_s1, fun2_s2;
  logic signed [3:0] inv2_s1, inv2_s2;
  logic              busy0, done0, seen0, busy2, done2, seen2;
  logic [4:0]        err0, rt0, err2, rt2;

  int checks = 0;
  int passed = 0;
  int ref_rt = 0;
  int done_at, busy_n, done_n;
  logic signed [7:0] cap_yiq;
  logic signed [3:0] cap_xq, cap_xiq;

  always #5 clk = ~clk;

  function automatic logic signed [7:0] f_quad(input logic signed [3:0] x);
    int xi;
    xi = x;
    return 8'(xi * xi + 10 * xi - 10);
  endfunction

  // Inverse LUT: lowest x whose quadratic gives y, or 0 if none does.
  function automatic logic signed [3:0] f_inv(input logic signed [7:0] y);
    for (int i = -8; i <= 7; i++) begin
      if (f_quad(4'(i)) == y) return 4'(i);
    end
    return 4'sd0;
  endfunction

  always_comb begin
    yq_fun0 = f_quad(xq0);
    yq_lut0 = yq_fun0 + 8'(((fault_p3 && xq0 == 4'sd3) || (fault_m2 && xq0 == -4'sd2)) ? 1 : 0);
    xiq0    = f_inv(yiq0);
  end

  always @(posedge clk) begin
    lut2_s1 <= f_quad(xq2);
    lut2_s2 <= lut2_s1;
    fun2_s1 <= f_quad(xq2);
    fun2_s2 <= fun2_s1;
    inv2_s1 <= f_inv(yiq2);
    inv2_s2 <= inv2_s1;
  end
  assign yq_lut2 = lut2_s2;
  assign yq_fun2 = fun2_s2;
  assign xiq2    = inv2_s2;

  lut_sweep_checker #(.W_X(4), .W_Y(8), .LAT(0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .abort(abort0),
    .xq(xq0), .yq_lut(yq_lut0), .yq_fun(yq_fun0), .yiq(yiq0), .xiq(xiq0),
    .busy(busy0), .done(done0), .err_count(err0), .err_seen(seen0),
    .first_err_x(first0), .rt_match_count(rt0)
  );

  lut_sweep_checker #(.W_X(4), .W_Y(8), .LAT(2)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .abort(abort2),
    .xq(xq2), .yq_lut(yq_lut2), .yq_fun(yq_fun2), .yiq(yiq2), .xiq(xiq2),
    .busy(busy2), .done(done2), .err_count(err2), .err_seen(seen2),
    .first_err_x(first2), .rt_match_count(rt2)
  );

  // Pulses start on dut0 and watches 120 cycles; j counts falling edges after the start edge.
  task automatic run_sweep(input int abort_at, input int sa, input int sb);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    done_at = -1; busy_n = 0; done_n = 0;
    for (int j = 0; j < 120; j++) begin
      if (busy0) busy_n++;
      if (done0) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
      if (j == 1) begin
        cap_yiq = yiq0; cap_xq = xq0; cap_xiq = xiq0;
      end
      start0 = (j == sa) || (j == sb);
      abort0 = (j == abort_at);
      @(negedge clk);
    end
    start0 = 1'b0;
    abort0 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({xq0, yiq0, busy0, done0, err0, seen0, first0, rt0} !== '0)
      $display("[TB] FAIL reset_dut0 got %h want 0", {xq0, yiq0, busy0, done0, err0, seen0, first0, rt0}); else passed++;
    checks++; if ({xq2, yiq2, busy2, done2, err2, seen2, first2, rt2} !== '0)
      $display("[TB] FAIL reset_dut2 got %h want 0", {xq2, yiq2, busy2, done2, err2, seen2, first2, rt2}); else passed++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_pass_results(input string tag);
    checks++; if (done_at !== 33) $display("[TB] FAIL %s_done_at got %0d want 33", tag, done_at); else passed++;
    checks++; if (done_n !== 1) $display("[TB] FAIL %s_done_pulses got %0d want 1", tag, done_n); else passed++;
    checks++; if (err0 !== 5'd0) $display("[TB] FAIL %s_err_count got %0d want 0", tag, err0); else passed++;
    checks++; if (seen0 !== 1'b0) $display("[TB] FAIL %s_err_seen got %0b want 0", tag, seen0); else passed++;
    checks++; if (rt0 !== 5'(ref_rt)) $display("[TB] FAIL %s_rt_match got %0d want %0d", tag, rt0, ref_rt); else passed++;
  endtask

  task automatic test_pass_sweep();
    run_sweep(-1, -1, -1);
    check_pass_results("pass");
    checks++; if (busy_n !== 32) $display("[TB] FAIL pass_busy_cycles got %0d want 32", busy_n); else passed++;
    checks++; if (cap_xq !== 4'sd0 || cap_yiq !== -8'sd10 || cap_xiq !== 4'sd0)
      $display("[TB] FAIL pass_point0 got xq=%0d yiq=%0d xiq=%0d want 0/-10/0", cap_xq, cap_yiq, cap_xiq); else passed++;
    checks++; if (rt0 !== 5'd13) $display("[TB] FAIL pass_rt_hand got %0d want 13", rt0); else passed++;
  endtask

  task automatic test_fault_injection();
    fault_p3 = 1'b1;
    run_sweep(-1, -1, -1);
    checks++; if (err0 !== 5'd1) $display("[TB] FAIL fault1_err_count got %0d want 1", err0); else passed++;
    checks++; if (seen0 !== 1'b1) $display("[TB] FAIL fault1_err_seen got %0b want 1", seen0); else passed++;
    checks++; if (first0 !== 4'sd3) $display("[TB] FAIL fault1_first_x got %0d want 3", first0); else passed++;
    fault_m2 = 1'b1;
    run_sweep(-1, -1, -1);
    checks++; if (err0 !== 5'd2) $display("[TB] FAIL fault2_err_count got %0d want 2", err0); else passed++;
    checks++; if (first0 !== 4'sd3) $display("[TB] FAIL fault2_first_x got %0d want 3", first0); else passed++;
    checks++; if (done_at !== 33) $display("[TB] FAIL fault2_done_at got %0d want 33", done_at); else passed++;
    fault_m2 = 1'b0;
  endtask

  task automatic test_abort();
    // Fault at x=3 is still on, so points 0..4 leave err=1, first=3, rt=4 before the abort.
    run_sweep(10, -1, -1);
    checks++; if (busy_n !== 11) $display("[TB] FAIL abort_busy_cycles got %0d want 11", busy_n); else passed++;
    checks++; if (done_n !== 0) $display("[TB] FAIL abort_done_pulses got %0d want 0", done_n); else passed++;
    checks++; if (err0 !== 5'd1 || seen0 !== 1'b1 || first0 !== 4'sd3)
      $display("[TB] FAIL abort_hold_err got %0d/%0b/%0d want 1/1/3", err0, seen0, first0); else passed++;
    checks++; if (rt0 !== 5'd4) $display("[TB] FAIL abort_hold_rt got %0d want 4", rt0); else passed++;
    checks++; if (xq0 !== 4'sd5) $display("[TB] FAIL abort_hold_xq got %0d want 5", xq0); else passed++;
    fault_p3 = 1'b0;
    run_sweep(-1, -1, -1);
    check_pass_results("after_abort");
    checks++; if (first0 !== 4'sd0) $display("[TB] FAIL after_abort_first_x got %0d want 0", first0); else passed++;
  endtask

  task automatic test_start_ignored();
    run_sweep(-1, 5, 20);
    check_pass_results("start_busy");
  endtask

  task automatic test_back_to_back();
    run_sweep(-1, 32, -1);
    checks++; if (done_n !== 1) $display("[TB] FAIL start_in_done_pulses got %0d want 1", done_n); else passed++;
    checks++; if (busy_n !== 32) $display("[TB] FAIL start_in_done_busy got %0d want 32", busy_n); else passed++;
  endtask

  task automatic test_start_abort_idle();
    fault_p3 = 1'b1;
    @(negedge clk) begin start0 = 1'b1; abort0 = 1'b1; end
    @(negedge clk) begin start0 = 1'b0; abort0 = 1'b0; end
    checks++; if (busy0 !== 1'b0) $display("[TB] FAIL idle_abort_busy got %0b want 0", busy0); else passed++;
    repeat (40) @(negedge clk);
    checks++; if (rt0 !== 5'(ref_rt) || err0 !== 5'd0)
      $display("[TB] FAIL idle_abort_counts got rt=%0d err=%0d want %0d/0", rt0, err0, ref_rt); else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (busy0 !== 1'b1 || err0 !== 5'd1)
      $display("[TB] FAIL midrst_pre got busy=%0b err=%0d want 1/1", busy0, err0); else passed++;
    #2 rstn = 1'b0;
    #1;
    checks++; if ({xq0, yiq0, busy0, done0, err0, seen0, first0, rt0} !== '0)
      $display("[TB] FAIL midrst_async got %h want 0", {xq0, yiq0, busy0, done0, err0, seen0, first0, rt0}); else passed++;
    fault_p3 = 1'b0;
    @(negedge clk) rstn = 1'b1;
    run_sweep(-1, -1, -1);
    check_pass_results("after_reset");
  endtask

  task automatic test_latency();
    int first_chg, second_chg;
    logic signed [3:0] prev;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    done_at = -1; first_chg = -1; second_chg = -1; prev = xq2;
    for (int j = 0; j < 250; j++) begin
      if (xq2 !== prev) begin
        if (first_chg < 0) first_chg = j;
        else if (second_chg < 0) second_chg = j;
        prev = xq2;
      end
      if (done2 && done_at < 0) done_at = j;
      @(negedge clk);
    end
    checks++; if (first_chg !== 6 || second_chg !== 12)
      $display("[TB] FAIL lat2_xq_step got %0d/%0d want 6/12", first_chg, second_chg); else passed++;
    checks++; if (done_at !== 97) $display("[TB] FAIL lat2_done_at got %0d want 97", done_at); else passed++;
    checks++; if (err2 !== 5'd0 || seen2 !== 1'b0)
      $display("[TB] FAIL lat2_err got %0d/%0b want 0/0", err2, seen2); else passed++;
    checks++; if (rt2 !== 5'(ref_rt)) $display("[TB] FAIL lat2_rt_match got %0d want %0d", rt2, ref_rt); else passed++;
  endtask

  initial begin
    for (int x = -8; x <= 7; x++) begin
      if (f_inv(f_quad(4'(x))) == 4'(x)) ref_rt++;
    end
    test_reset();
    test_pass_sweep();
    test_fault_injection();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_start_abort_idle();
    test_reset_mid_sweep();
    test_latency();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
